// File: rtl/shared_port_arbiter_rr.sv
// Shared cache-port arbiter: lets NCORES requesters share one val/rdy cache request port.
//
// A round-robin grant picks a requester. A hold lock keeps a stalled request on the port
// until the cache accepts it. A core-ID field is appended to the tag, so each response can
// be routed back to the core that issued it. Per-core outstanding counters drive
// core_quiescent, which lets the integration level drain a core before resetting it.
//
// Optional build macro: ARB_OUTSTANDING_LIMIT_EN
//   defined   - a core is blocked once it has MAX_OUTST requests in flight
//   undefined - a core is blocked only when its counter is full (2^CNT_W-1)
//
// Ports:
//   clk, reset        clock and synchronous active-high global reset
//   core_reset        per-core reset; masks that core's requests and responses
//   core_req_*        packed per-core request channels (core i at [i*W +: W])
//   core_req_rdy      per-core ready; at most one bit set, on the granted core
//   core_resp_*       one-hot response valid; data and stripped tag broadcast to all cores
//   core_quiescent    per-core "no requests in flight"
//   cache_req_*       request to the cache; the tag is {grant_id, core tag}
//   cache_resp_*      response from the cache; the tag is {id, core tag} as issued
module shared_port_arbiter_rr #(
  parameter int unsigned NCORES    = 4,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned TAG_W     = 15,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned ID_W     = (NCORES > 1) ? $clog2(NCORES) : 1,
  localparam int unsigned MASK_W   = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCORES-1:0]          core_reset,
  input  logic [NCORES-1:0]          core_req_val,
  output logic [NCORES-1:0]          core_req_rdy,
  input  logic [NCORES*OP_W-1:0]     core_req_op,
  input  logic [NCORES*ADDR_W-1:0]   core_req_addr,
  input  logic [NCORES*DATA_W-1:0]   core_req_data,
  input  logic [NCORES*MASK_W-1:0]   core_req_wmask,
  input  logic [NCORES*TAG_W-1:0]    core_req_tag,
  output logic [NCORES-1:0]          core_resp_val,
  output logic [DATA_W-1:0]          core_resp_data,
  output logic [TAG_W-1:0]           core_resp_tag,
  output logic [NCORES-1:0]          core_quiescent,
  output logic                       cache_req_val,
  input  logic                       cache_req_rdy,
  output logic [OP_W-1:0]            cache_req_op,
  output logic [ADDR_W-1:0]          cache_req_addr,
  output logic [DATA_W-1:0]          cache_req_data,
  output logic [MASK_W-1:0]          cache_req_wmask,
  output logic [TAG_W+ID_W-1:0]      cache_req_tag,
  input  logic                       cache_resp_val,
  input  logic [DATA_W-1:0]          cache_resp_data,
  input  logic [TAG_W+ID_W-1:0]      cache_resp_tag
);

  // Parameter sanity checks at elaboration time.
  if (NCORES < 1 || NCORES > 16) begin : g_bad_ncores
    $error("NCORES must be in 1..16");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > (1 << CNT_W) - 1) begin : g_bad_max_outst
    $error("MAX_OUTST must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CntFull = {CNT_W{1'b1}};
`ifdef ARB_OUTSTANDING_LIMIT_EN
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(MAX_OUTST);
`else
  localparam logic [CNT_W-1:0] CntLimit = CntFull;
`endif

  typedef enum logic {StFree, StLocked} lock_state_e;

  lock_state_e       lock_state_q, lock_state_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q [NCORES];
  logic [CNT_W-1:0]  cnt_d [NCORES];

  logic [NCORES-1:0] cnt_block;
  logic [NCORES-1:0] elig;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic              grant_found;
  logic              handshake;
  logic [ID_W-1:0]   resp_id;
  logic              cnt_inc;
  logic              cnt_dec;

  // Eligibility; global reset also masks everything so nothing leaves while reset is high.
  always_comb begin
    cnt_block = '0;
    elig      = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      cnt_block[i] = (cnt_q[i] >= CntLimit);
      elig[i]      = core_req_val[i] & ~core_reset[i] & ~cnt_block[i] & ~reset;
    end
  end

  // Grant: a still-eligible locked core wins; otherwise search upward from rr_ptr.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    if (lock_state_q == StLocked && elig[lock_id_q]) begin
      grant       = lock_id_q;
      grant_found = 1'b1;
    end
    for (int unsigned k = 0; k < NCORES; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NCORES);
      if (!grant_found && elig[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  assign cache_req_val   = |elig;
  assign handshake       = cache_req_val & cache_req_rdy;
  assign cache_req_op    = core_req_op[int'(grant) * OP_W +: OP_W];
  assign cache_req_addr  = core_req_addr[int'(grant) * ADDR_W +: ADDR_W];
  assign cache_req_data  = core_req_data[int'(grant) * DATA_W +: DATA_W];
  assign cache_req_wmask = core_req_wmask[int'(grant) * MASK_W +: MASK_W];
  assign cache_req_tag   = {grant, core_req_tag[int'(grant) * TAG_W +: TAG_W]};

  always_comb begin
    core_req_rdy = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      core_req_rdy[i] = cache_req_rdy & elig[i] & (grant == ID_W'(i));
    end
  end

  // Response routing. IDs at or above NCORES match no channel and are dropped.
  assign resp_id        = cache_resp_tag[TAG_W +: ID_W];
  assign core_resp_data = cache_resp_data;
  assign core_resp_tag  = cache_resp_tag[TAG_W-1:0];

  always_comb begin
    core_resp_val = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      core_resp_val[i] = cache_resp_val & ~reset & ~core_reset[i] & (resp_id == ID_W'(i));
    end
  end

  // Arbitration state: a refused request locks the port to its core until it is accepted
  // or withdrawn.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_id_d    = lock_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (handshake) begin
      rr_ptr_d     = ID_W'((32'(grant) + 1) % NCORES);
      lock_state_d = StFree;
    end else if (cache_req_val) begin
      lock_state_d = StLocked;
      lock_id_d    = grant;
    end else begin
      lock_state_d = StFree;
    end
  end

  // Outstanding counters. A response still decrements while its core is in core_reset,
  // because the request really did complete at the cache.
  always_comb begin
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      cnt_inc  = handshake & (grant == ID_W'(i));
      cnt_dec  = cache_resp_val & (resp_id == ID_W'(i));
      cnt_d[i] = cnt_q[i];
      if (cnt_inc && !cnt_dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (cnt_dec && !cnt_inc && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    core_quiescent = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      core_quiescent[i] = (cnt_q[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state_q <= StFree;
      lock_id_q    <= '0;
      rr_ptr_q     <= '0;
      for (int unsigned i = 0; i < NCORES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lock_state_q <= lock_state_d;
      lock_id_q    <= lock_id_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int unsigned i = 0; i < NCORES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_shared_port_arbiter_rr.sv
// Randomised scoreboard bench for shared_port_arbiter_rr. The driver issues stimulus at
// each negedge and a spec-level model pushes expectations. A monitor then pops them and
// compares them against the DUT a little later in the same low phase.
module tb_shared_port_arbiter_rr;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned MO = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned MW = DW / 8;
`ifdef ARB_OUTSTANDING_LIMIT_EN
  localparam int Cap = MO;
`else
  localparam int Cap = (1 << CW) - 1;
`endif
  localparam int NCYC = 3100;

  localparam int MRst = 0, MAll = 1, MDrain = 2, MHog0 = 3, MHog01 = 4, MRand = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [N-1:0]        core_reset, core_req_val, core_req_rdy;
  logic [N*OW-1:0]     core_req_op;
  logic [N*AW-1:0]     core_req_addr;
  logic [N*DW-1:0]     core_req_data;
  logic [N*MW-1:0]     core_req_wmask;
  logic [N*TW-1:0]     core_req_tag;
  logic [N-1:0]        core_resp_val, core_quiescent;
  logic [DW-1:0]       core_resp_data;
  logic [TW-1:0]       core_resp_tag;
  logic                cache_req_val, cache_req_rdy;
  logic [OW-1:0]       cache_req_op;
  logic [AW-1:0]       cache_req_addr;
  logic [DW-1:0]       cache_req_data;
  logic [MW-1:0]       cache_req_wmask;
  logic [TW+IW-1:0]    cache_req_tag;
  logic                cache_resp_val;
  logic [DW-1:0]       cache_resp_data;
  logic [TW+IW-1:0]    cache_resp_tag;

  shared_port_arbiter_rr #(
    .NCORES(N), .ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .TAG_W(TW), .CNT_W(CW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .reset(reset), .core_reset(core_reset),
    .core_req_val(core_req_val), .core_req_rdy(core_req_rdy), .core_req_op(core_req_op),
    .core_req_addr(core_req_addr), .core_req_data(core_req_data),
    .core_req_wmask(core_req_wmask), .core_req_tag(core_req_tag),
    .core_resp_val(core_resp_val), .core_resp_data(core_resp_data),
    .core_resp_tag(core_resp_tag), .core_quiescent(core_quiescent),
    .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy),
    .cache_req_op(cache_req_op), .cache_req_addr(cache_req_addr),
    .cache_req_data(cache_req_data), .cache_req_wmask(cache_req_wmask),
    .cache_req_tag(cache_req_tag), .cache_resp_val(cache_resp_val),
    .cache_resp_data(cache_resp_data), .cache_resp_tag(cache_resp_tag)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [OW-1:0] op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] wmask;
    logic [TW-1:0] tag;
  } req_t;
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;
  typedef struct {
    logic [N-1:0] rdy;
    logic [N-1:0] quiet;
    logic [N-1:0] rval;
    logic         cval;
  } cyc_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  cyc_t cyc_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: plain per-core counts, a next-in-line pointer and a held core.
  int m_cnt [N];
  int m_rr;
  bit m_locked;
  int m_lock_core;

  // Stimulus state.
  bit            pend [N];
  int            crst_left [N];
  logic [OW-1:0] f_op [N];
  logic [AW-1:0] f_addr [N];
  logic [DW-1:0] f_data [N];
  logic [MW-1:0] f_wmask [N];
  logic [TW-1:0] f_tag [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mode_of(input int cyc);
    if (cyc < 3) return MRst;
    if (cyc < 13) return MAll;
    if (cyc < 29) return MDrain;
    if (cyc < 53) return MHog0;
    if (cyc < 63) return MHog01;
    if (cyc < 101) return MDrain;
    if (cyc < 1501) return MRand;
    if (cyc < 1503) return MRst;
    if (cyc < 3000) return MRand;
    return MDrain;
  endfunction

  task automatic new_req(input int i);
    pend[i]    = 1'b1;
    f_op[i]    = OW'($urandom);
    f_addr[i]  = AW'($urandom);
    f_data[i]  = DW'($urandom);
    f_wmask[i] = MW'($urandom);
    f_tag[i]   = TW'($urandom);
  endtask

  task automatic drive(input int cyc);
    int mode;
    int start;
    int id;
    mode  = mode_of(cyc);
    reset = (mode == MRst);
    for (int i = 0; i < N; i++) begin
      if (mode == MRand && crst_left[i] == 0 && ($urandom % 64) == 0)
        crst_left[i] = int'($urandom_range(1, 6));
      if (mode != MRand) crst_left[i] = 0;
      core_reset[i] = (crst_left[i] > 0);
      if (crst_left[i] > 0) crst_left[i]--;
      if (!pend[i] && (mode == MAll || ($urandom % 2) == 0)) new_req(i);
      if ((mode == MHog0 && i == 0) || (mode == MHog01 && i < 2)) begin
        if (!pend[i]) new_req(i);
      end
      case (mode)
        MAll:    core_req_val[i] = 1'b1;
        MHog0:   core_req_val[i] = (i == 0);
        MHog01:  core_req_val[i] = (i < 2);
        MRand:   core_req_val[i] = pend[i] && (($urandom % 16) != 0);
        MRst:    core_req_val[i] = 1'($urandom);
        default: core_req_val[i] = 1'b0;
      endcase
      core_req_op[i*OW +: OW]    = f_op[i];
      core_req_addr[i*AW +: AW]  = f_addr[i];
      core_req_data[i*DW +: DW]  = f_data[i];
      core_req_wmask[i*MW +: MW] = f_wmask[i];
      core_req_tag[i*TW +: TW]   = f_tag[i];
    end
    cache_req_rdy   = (mode == MRand || mode == MDrain) ? (($urandom % 4) != 0) : 1'b1;
    cache_resp_val  = 1'b0;
    cache_resp_data = DW'($urandom);
    id              = int'($urandom_range(0, N - 1));
    if (mode == MDrain) begin
      start = int'($urandom_range(0, N - 1));
      for (int k = N - 1; k >= 0; k--) begin
        if (m_cnt[(start + k) % N] > 0) begin
          id             = (start + k) % N;
          cache_resp_val = 1'b1;
        end
      end
    end else if (mode == MRand || mode == MRst) begin
      cache_resp_val = (($urandom % 3) == 0);
    end
    cache_resp_tag = {IW'(id), TW'($urandom)};
  endtask

  task automatic model_step();
    bit [N-1:0] elig;
    int   g;
    int   id;
    bit   any;
    bit   hs;
    cyc_t e;
    req_t r;
    rsp_t s;
    for (int i = 0; i < N; i++)
      elig[i] = !reset && core_req_val[i] && !core_reset[i] && (m_cnt[i] < Cap);
    any = |elig;
    g   = -1;
    if (m_locked && elig[m_lock_core]) g = m_lock_core;
    else
      for (int k = 0; k < N; k++)
        if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
    hs     = any && cache_req_rdy;
    e.rdy  = '0;
    e.rval = '0;
    e.cval = any;
    if (hs) e.rdy[g] = 1'b1;
    for (int i = 0; i < N; i++) e.quiet[i] = (m_cnt[i] == 0);
    id = int'(cache_resp_tag[TW +: IW]);
    if (!reset && cache_resp_val && id < N && !core_reset[id]) begin
      e.rval[id] = 1'b1;
      s.data     = cache_resp_data;
      s.tag      = cache_resp_tag[TW-1:0];
      rsp_q.push_back(s);
    end
    cyc_q.push_back(e);
    if (hs) begin
      r.id    = IW'(g);
      r.op    = f_op[g];
      r.addr  = f_addr[g];
      r.data  = f_data[g];
      r.wmask = f_wmask[g];
      r.tag   = f_tag[g];
      req_q.push_back(r);
    end
    if (reset) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr     = 0;
      m_locked = 0;
    end else begin
      if (hs) begin
        m_cnt[g]++;
        m_rr     = (g + 1) % N;
        m_locked = 0;
        pend[g]  = 1'b0;
      end else if (any) begin
        m_locked    = 1;
        m_lock_core = g;
      end else begin
        m_locked = 0;
      end
      if (cache_resp_val && id < N && m_cnt[id] > 0) m_cnt[id]--;
    end
  endtask

  // Monitor: runs 2 time units after each negedge, after the driver has pushed.
  cyc_t mon_e;
  req_t mon_r;
  rsp_t mon_s;
  always @(negedge clk) begin
    #2;
    check("cycle_record_present", 64'(cyc_q.size() != 0), 64'd1);
    if (cyc_q.size() != 0) begin
      mon_e = cyc_q.pop_front();
      check("core_req_rdy", 64'(core_req_rdy), 64'(mon_e.rdy));
      check("core_quiescent", 64'(core_quiescent), 64'(mon_e.quiet));
      check("core_resp_val", 64'(core_resp_val), 64'(mon_e.rval));
      check("cache_req_val", 64'(cache_req_val), 64'(mon_e.cval));
    end
    if (cache_req_val && cache_req_rdy) begin
      check("handshake_expected", 64'(req_q.size() != 0), 64'd1);
      if (req_q.size() != 0) begin
        mon_r = req_q.pop_front();
        check("grant_id", 64'(cache_req_tag[TW +: IW]), 64'(mon_r.id));
        check("req_tag", 64'(cache_req_tag[TW-1:0]), 64'(mon_r.tag));
        check("req_op", 64'(cache_req_op), 64'(mon_r.op));
        check("req_addr", 64'(cache_req_addr), 64'(mon_r.addr));
        check("req_data", 64'(cache_req_data), 64'(mon_r.data));
        check("req_wmask", 64'(cache_req_wmask), 64'(mon_r.wmask));
      end
    end
    check("req_left_unissued", 64'(req_q.size()), 64'd0);
    req_q.delete();
    if (|core_resp_val) begin
      check("resp_expected", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        mon_s = rsp_q.pop_front();
        check("resp_data", 64'(core_resp_data), 64'(mon_s.data));
        check("resp_tag", 64'(core_resp_tag), 64'(mon_s.tag));
      end
    end
    check("resp_left_undelivered", 64'(rsp_q.size()), 64'd0);
    rsp_q.delete();
  end

  initial begin
    reset           = 1'b1;
    core_reset      = '0;
    core_req_val    = '0;
    core_req_op     = '0;
    core_req_addr   = '0;
    core_req_data   = '0;
    core_req_wmask  = '0;
    core_req_tag    = '0;
    cache_req_rdy   = 1'b0;
    cache_resp_val  = 1'b0;
    cache_resp_data = '0;
    cache_resp_tag  = '0;
    m_rr            = 0;
    m_locked        = 0;
    m_lock_core     = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]     = 0;
      pend[i]      = 1'b0;
      crst_left[i] = 0;
      f_op[i]      = '0;
      f_addr[i]    = '0;
      f_data[i]    = '0;
      f_wmask[i]   = '0;
      f_tag[i]     = '0;
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      drive(cyc);
      #1;
      model_step();
    end
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
